// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table (active-high {g,f,e,d,c,b,a})
// and the index-width helper used by the interface and the top.
package seg7_pkg;

    localparam logic [6:0] SEG7_OFF = 7'h00;

    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // A single-digit display still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Register-file side (value/dp/blank/load/en) and display-pin side of the scan driver.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8
);
    localparam int IDX_W = idx_w(DIGITS);

    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [6:0]            seg;
    logic                  seg_dp;
    logic [DIGITS-1:0]     an;
    logic [IDX_W-1:0]      digit_idx;

    modport master (
        output en, load, value, dp, blank,
        input  seg, seg_dp, an, digit_idx
    );

    modport slave (
        input  en, load, value, dp, blank,
        output seg, seg_dp, an, digit_idx
    );
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational nibble to active-high segment pattern; polarity is applied by the caller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG7_GLYPH[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: shadow registers, slot/digit counters,
// leading-zero suppression and registered, polarity-adjusted pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SLOT_CYC   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);
    localparam int   IDX_W = idx_w(DIGITS);
    localparam int   CNT_W = idx_w(SLOT_CYC);
    localparam logic INV   = (ACTIVE_LOW != 0);
    localparam logic LZ    = (LZ_BLANK != 0);

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [6:0]          r_seg;
    logic                r_seg_dp;
    logic [DIGITS-1:0]   r_an;

    logic [3:0]          w_nib [DIGITS];
    logic [DIGITS-1:0]   w_upper_zero;
    logic [DIGITS-1:0]   w_an_hi;
    logic [6:0]          w_glyph;
    logic                w_dark;
    logic                w_lit;
    logic                w_an_on;
    logic                w_wrap;

    // w_upper_zero[gi]: every nibble from gi up to the leftmost digit is zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_nib[gi]        = r_value[4*gi +: 4];
        assign w_upper_zero[gi] = (r_value[4*DIGITS-1:4*gi] == '0);
        assign w_an_hi[gi]      = w_an_on && (r_idx == IDX_W'(gi));
    end

    seg7_hex_decode u_decode (
        .i_nib (w_nib[r_idx]),
        .o_seg (w_glyph)
    );

    assign w_dark  = r_blank[r_idx] | (LZ && (r_idx != '0) && w_upper_zero[r_idx]);
    assign w_lit   = bus.en && !w_dark;
    assign w_an_on = w_lit && (r_cnt >= CNT_W'(BLANK_CYC));
    assign w_wrap  = (r_cnt == CNT_W'(SLOT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value  <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_seg    <= {7{INV}};
            r_seg_dp <= INV;
            r_an     <= {DIGITS{INV}};
        end else begin
            if (bus.load) begin
                r_value <= bus.value;
                r_dp    <= bus.dp;
                r_blank <= bus.blank;
            end
            if (bus.en) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // Outputs are computed from pre-edge state, so a load on a wrap edge cannot tear.
            r_seg    <= (w_lit ? w_glyph : SEG7_OFF) ^ {7{INV}};
            r_seg_dp <= (w_lit && r_dp[r_idx]) ^ INV;
            r_an     <= w_an_hi ^ {DIGITS{INV}};
        end
    end

    assign bus.seg       = r_seg;
    assign bus.seg_dp    = r_seg_dp;
    assign bus.an        = r_an;
    assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed checks of seg7_scan_driver against a position-based display model.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK),
        .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Active-low glyphs {g..a} for 0-9, A, b, C, d, E, F.
    logic [6:0] glyph_al [16];

    // Model: pos counts enabled cycles since reset; slot/index follow from it.
    int          pos;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp, sh_blank;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    int          exp_idx;

    function automatic int pcount(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic step(input string tag);
        int  cnt, idx;
        bit  dark;
        @(posedge clk);
        cnt = pos % SLOT;
        idx = (pos / SLOT) % DIGITS;
        dark = sh_blank[idx] || (idx > 0 && (sh_val >> (4 * idx)) == 16'd0);
        if (rst || !bus.en || dark) begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
        end else begin
            exp_seg = glyph_al[(sh_val >> (4 * idx)) & 16'hF];
            exp_dp  = ~sh_dp[idx];
            exp_an  = (cnt >= BLANK) ? ~(4'b0001 << idx) : 4'hF;
        end
        if (rst) begin
            pos = 0; sh_val = '0; sh_dp = '0; sh_blank = '0;
        end else begin
            if (bus.en)   pos = (pos + 1) % (SLOT * DIGITS);
            if (bus.load) begin
                sh_val = bus.value; sh_dp = bus.dp; sh_blank = bus.blank;
            end
        end
        exp_idx = (pos / SLOT) % DIGITS;
        #1;
        chk({tag, ".seg"}, 32'(bus.seg), 32'(exp_seg));
        chk({tag, ".dp"},  32'(bus.seg_dp), 32'(exp_dp));
        chk({tag, ".an"},  32'(bus.an), 32'(exp_an));
        chk({tag, ".idx"}, 32'(bus.digit_idx), 32'(exp_idx));
        chk({tag, ".onehot"}, 32'(pcount(~bus.an) <= 1), 32'd1);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_load(input string tag, input logic [15:0] v,
                           input logic [3:0] d, input logic [3:0] b);
        bus.value = v; bus.dp = d; bus.blank = b; bus.load = 1'b1;
        step(tag);
        bus.load = 1'b0;
    endtask

    initial begin
        glyph_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        pos = 0; sh_val = '0; sh_dp = '0; sh_blank = '0;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = '0;

        // 1. reset held, then idle with en=0
        run("reset", 3);
        rst = 1'b0;
        run("idle", 10);
        chk("idle.seg_const", 32'(bus.seg), 32'h7F);

        // 2. basic scan of 12AF
        bus.en = 1'b1;
        do_load("scan", 16'h12AF, 4'h0, 4'h0);
        for (int i = 0; i < 2 * SLOT * DIGITS; i++) begin
            step("scan");
            if (bus.an == 4'b1110) chk("scan.glyphF", 32'(bus.seg), 32'(7'b0001110));
            if (bus.an == 4'b1101) chk("scan.glyphA", 32'(bus.seg), 32'(7'b0001000));
            if (bus.an == 4'b1011) chk("scan.glyph2", 32'(bus.seg), 32'(7'b0100100));
            if (bus.an == 4'b0111) chk("scan.glyph1", 32'(bus.seg), 32'(7'b1111001));
        end

        // 3. leading-zero suppression
        do_load("lz40", 16'h0040, 4'h0, 4'h0);
        run("lz40", SLOT * DIGITS + 2);
        do_load("lz00", 16'h0000, 4'h0, 4'h0);
        for (int i = 0; i < SLOT * DIGITS; i++) begin
            step("lz00");
            chk("lz00.only0", 32'(bus.an == 4'hF || bus.an == 4'b1110), 32'd1);
        end

        // 4. decimal point and blank mask
        do_load("dpbl", 16'h12AF, 4'b0100, 4'b0001);
        run("dpbl", 2 * SLOT * DIGITS);

        // 5. value change without load, then load on a wrap edge
        bus.value = 16'h9876;
        run("noload", SLOT * DIGITS);
        while ((pos % SLOT) != SLOT - 1) step("align");
        do_load("wrapload", 16'h3C5E, 4'b1010, 4'h0);
        run("wrapload", SLOT * DIGITS);

        // 6. reset mid-slot at idx2, counter=5
        for (int i = 0; i < 2 * SLOT * DIGITS && pos != 2 * SLOT + 5; i++) step("seek");
        chk("seek.pos", 32'(pos), 32'(2 * SLOT + 5));
        rst = 1'b1;
        step("midrst");
        chk("midrst.idx0", 32'(bus.digit_idx), 32'd0);
        rst = 1'b0;
        step("postrst");
        chk("postrst.an", 32'(bus.an), 32'hF);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bus.en    = ($urandom_range(0, 9) != 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus.value = bus.value & 16'h00FF;
            bus.dp    = 4'($urandom);
            bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.load  = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step("rand");
        end
        rst = 1'b0; bus.load = 1'b0;
        step("tail");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
